// File: rtl/instruction_fetch_pkg.sv
// Shared constants, IF/ID payload and next-PC select encoding for the instruction-fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned INST_MEM_SIZE = 1024;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_HOLD   = 2'd3
  } pc_sel_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: stall > jump > branch > sequential; also flags redirect and misalignment.
module next_pc_sel
  import instruction_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] next_pc_c,
  output logic            redirect_c,
  output logic            misalign_c
);

  pc_sel_e         sel_c;
  logic [XLEN-1:0] target_c;

  always_comb begin : sel_decode
    sel_c = SEL_SEQ;
    if (stall) begin
      sel_c = SEL_HOLD;
    end else if (jump_en) begin
      sel_c = SEL_JUMP;
    end else if (branch_taken) begin
      sel_c = SEL_BRANCH;
    end
  end

  always_comb begin : target_mux
    target_c = branch_target;
    if (jump_en) begin
      target_c = jump_target;
    end
  end

  always_comb begin : pc_mux
    next_pc_c = pc_plus4;
    case (sel_c)
      SEL_HOLD:   next_pc_c = pc;
      SEL_JUMP:   next_pc_c = word_align(jump_target);
      SEL_BRANCH: next_pc_c = word_align(branch_target);
      default:    next_pc_c = pc_plus4;
    endcase
  end

  assign redirect_c = (sel_c == SEL_JUMP) || (sel_c == SEL_BRANCH);
  assign misalign_c = redirect_c && (target_c[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch.sv
// MIPS32 IF stage: PC register, next-PC select and IF/ID register with stall/flush/redirect bubbles.
// Optional FETCH_ALIGN_CHK_EN: pulse misalign_fault one cycle after a misaligned accepted redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic            ifid_valid,
  output logic            misalign_fault
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] next_pc_c;
  logic            redirect_c;
  logic            misalign_c;
  ifid_t           ifid_q;
  ifid_t           ifid_d_c;

  // 32-bit modulo increment; wraps FFFF_FFFC to 0
  assign pc_plus4_c = pc_q + XLEN'(4);

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4_c),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .next_pc_c     (next_pc_c),
    .redirect_c    (redirect_c),
    .misalign_c    (misalign_c)
  );

  // Wrong-path word in a redirect cycle is squashed; flush overrides stall here only
  always_comb begin : ifid_next
    ifid_d_c = ifid_q;
    if (flush || redirect_c) begin
      ifid_d_c.instr    = NOP_INSTR;
      ifid_d_c.pc_plus4 = '0;
      ifid_d_c.valid    = 1'b0;
    end else if (!stall) begin
      ifid_d_c.instr    = imem_instr;
      ifid_d_c.pc_plus4 = pc_plus4_c;
      ifid_d_c.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : pc_reg
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : ifid_reg
    if (rst) begin
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc_plus4 <= '0;
      ifid_q.valid    <= 1'b0;
    end else begin
      ifid_q <= ifid_d_c;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin : misalign_reg
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_c;
    end
  end

  assign misalign_fault = misalign_q;
`else
  logic unused_misalign;

  assign unused_misalign = misalign_c;
  assign misalign_fault  = 1'b0;
`endif

  assign pc            = pc_q;
  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, random run against a reference model, async reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        misalign_fault;

  logic [31:0] mem [0:1023];
  int checks   = 0;
  int failures = 0;

`ifdef FETCH_ALIGN_CHK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[11:2]];

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .pc             (pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_valid     (ifid_valid),
    .misalign_fault (misalign_fault)
  );

  typedef struct {
    logic        s;
    logic        f;
    logic        b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_fault;

  function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic [31:0] ep,
                              input logic [31:0] ei, input logic [31:0] e4, input logic ev,
                              input logic ef);
    vec_t v;
    v.s = s; v.f = f; v.b = b; v.bt = bt; v.j = j; v.jt = jt;
    v.e_pc = ep; v.e_instr = ei; v.e_pc4 = e4; v.e_valid = ev; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ep, input logic [31:0] ei,
                           input logic [31:0] e4, input logic ev, input logic ef);
    check({tag, "_pc"}, pc, ep);
    check({tag, "_imem_addr"}, imem_addr, ep);
    check({tag, "_instr"}, ifid_instr, ei);
    check({tag, "_pc4"}, ifid_pc_plus4, e4);
    check({tag, "_valid"}, 32'(ifid_valid), 32'(ev));
    check({tag, "_fault"}, 32'(misalign_fault), 32'(ef));
  endtask

  task automatic set_idle();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  // One edge of the specification's rules, evaluated before the edge using current inputs
  task automatic model_step();
    logic        redir;
    logic [31:0] tgt;
    redir   = (jump_en || branch_taken) && !stall;
    tgt     = jump_en ? jump_target : branch_target;
    m_fault = ALIGN && redir && ((tgt % 32'd4) != 32'd0);
    if (flush || redir) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem[int'((m_pc / 32'd4) % 32'd1024)];
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    if (!stall) m_pc = redir ? (tgt - (tgt % 32'd4)) : (m_pc + 32'd4);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'h0211_4020;
    mem[1] = 32'h0253_4821;

    rst = 1'b1;
    set_idle();
    #2;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Directed table: inputs held for one edge, expected state after that edge
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h4,        32'h0211_4020, 32'h4,   1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h8,        32'h0253_4821, 32'h8,   1,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0, 32'h8,        32'h0253_4821, 32'h8,   1,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0, 32'h8,        32'h0253_4821, 32'h8,   1,0));
    vecs.push_back(mk(1,0,0,32'h0,0,32'h0, 32'h8,        32'h0253_4821, 32'h8,   1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'hC,        32'hC0DE_0002, 32'hC,   1,0));
    vecs.push_back(mk(0,0,1,32'h40,0,32'h0, 32'h40,      32'h0,         32'h0,   0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h44,       32'hC0DE_0010, 32'h44,  1,0));
    vecs.push_back(mk(0,0,1,32'h40,1,32'h80, 32'h80,     32'h0,         32'h0,   0,0));
    vecs.push_back(mk(1,0,1,32'h40,1,32'h80, 32'h80,     32'h0,         32'h0,   0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h84,       32'hC0DE_0020, 32'h84,  1,0));
    vecs.push_back(mk(1,1,0,32'h0,0,32'h0, 32'h84,       32'h0,         32'h0,   0,0));
    vecs.push_back(mk(0,1,0,32'h0,0,32'h0, 32'h88,       32'h0,         32'h0,   0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h8C,       32'hC0DE_0022, 32'h8C,  1,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'h102, 32'h100,    32'h0,         32'h0,   0,ALIGN));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h104,      32'hC0DE_0040, 32'h104, 1,0));
    vecs.push_back(mk(0,0,0,32'h0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h0,        32'hC0DE_03FF, 32'h0,   1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,32'h0, 32'h4,        32'h0211_4020, 32'h4,   1,0));
    vecs.push_back(mk(0,0,1,32'h203,0,32'h0, 32'h200,    32'h0,         32'h0,   0,ALIGN));

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      stall = vecs[i].s; flush = vecs[i].f;
      branch_taken = vecs[i].b; branch_target = vecs[i].bt;
      jump_en = vecs[i].j; jump_target = vecs[i].jt;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                vecs[i].e_valid, vecs[i].e_fault);
      @(negedge clk);
    end

    // Random run against the reference model
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 11) == 0);
      branch_taken  = ($urandom_range(0, 6) == 0);
      jump_en       = ($urandom_range(0, 8) == 0);
      branch_target = $urandom();
      jump_target   = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 4095));
      model_step();
      @(posedge clk);
      #1;
      check_all($sformatf("r%0d", n), m_pc, m_instr, m_pc4, m_valid, m_fault);
      @(negedge clk);
    end

    // Async reset mid-cycle with a redirect pending
    set_idle();
    jump_en = 1'b1; jump_target = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    set_idle();
    @(posedge clk); #1;
    check("pre_areset_valid", 32'(ifid_valid), 32'h1);
    @(negedge clk);
    jump_en = 1'b1; jump_target = 32'h500;
    #2;
    rst = 1'b1;
    #1;
    check_all("areset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("areset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("post_areset", 32'h4, 32'h0211_4020, 32'h4, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Instruction-fetch (IF) stage of the 5-stage MIPS32 pipeline.
- Owns the program counter and drives the address of the combinational-read `instruction_memory`.
- Selects the next PC from sequential, branch and jump sources, and registers the fetched word into the IF/ID pipeline register.
- Honours hazard-unit stall/flush; no branch delay slots.

## Interface

- `RESET_PC`, `32'h0000_0000`: PC value loaded on reset.
- `NOP_INSTR`, `32'h0000_0000`: encoding injected into IF/ID on a bubble.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  hazard unit: load bubble into IF/ID.
- `branch_taken`  in  1  resolved taken branch from ID.
- `branch_target`  in  32  branch destination byte address.
- `jump_en`  in  1  J/JAL/JR redirect from ID.
- `jump_target`  in  32  jump destination byte address.
- `imem_addr`  out  32  to `instruction_memory.addr`; equals `pc`.
- `imem_instr`  in  32  from `instruction_memory.instruction` (same-cycle combinational).
- `pc`  out  32  current fetch PC.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc_plus4`  out  32  registered PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `misalign_fault`  out  1  registered one-cycle pulse on a misaligned redirect (see Configuration).

## Operation

- Redirect: `redirect = (jump_en | branch_taken) & ~stall`.
- PC next-state, in priority order:
  - `rst` → `RESET_PC`.
  - `stall` → hold.
  - `jump_en` → `{jump_target[31:2],2'b00}`.
  - `branch_taken` → `{branch_target[31:2],2'b00}`.
  - otherwise → `pc+4`.
- `jump_en` beats `branch_taken` when both are asserted.
- IF/ID next-state, in priority order:
  - `rst` → `NOP_INSTR`, 0, 0.
  - `flush | redirect` → `NOP_INSTR`, `pc_plus4`=0, `valid`=0.
  - `stall` → hold.
  - otherwise → `imem_instr`, `pc+4`, 1.
- Flush beats stall for IF/ID only; PC still holds under stall.
- The word fetched in a redirect cycle is wrong-path and is squashed (no delay slot).
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC` + 4 → `32'h0000_0000`. No saturation, no trap.
- Addresses ≥ 4 KB alias in memory (memory indexes `addr[11:2]`); this block does not check range.
- `imem_addr` is a pure wire from the PC register: no logic between them.

## Timing

- Reset values:
  - `pc` = `imem_addr` = `RESET_PC`.
  - `ifid_instr` = `NOP_INSTR`, `ifid_pc_plus4` = 0, `ifid_valid` = 0.
  - `misalign_fault` = 0.
- Asynchronous assert takes effect immediately, independent of `clk`.
- Reset asserted mid-stream discards IF/ID contents and any pending redirect.
- Fetch latency: 1 cycle from `pc` to `ifid_*`.
- First edge after reset deassert: IF/ID ← `mem[RESET_PC>>2]`, `pc` ← `RESET_PC+4`.
- Throughput: one instruction per cycle when `stall`=0.
- Redirect penalty: exactly 1 bubble cycle; the target instruction appears in IF/ID two edges after the redirect cycle.
- `stall` held N cycles: PC and IF/ID frozen for N edges; fetch resumes at the same PC.
- `stall`, `flush`, `branch_taken` and `jump_en` are sampled only at the rising edge; no handshakes back to ID.

## Configuration

- Macro: `FETCH_ALIGN_CHK_EN`.
- Defined:
  - An accepted redirect whose selected target has bits [1:0] ≠ 0 sets `misalign_fault` high for exactly the following cycle.
  - The PC still loads the word-aligned target; the IF/ID bubble still applies.
- Undefined:
  - Target bits [1:0] are silently dropped.
  - `misalign_fault` is tied to 0; the port list is identical in both builds.

## Structure

- `RESET_PC` default, `NOP_INSTR` and the existing `INST_MEM_SIZE` live in `mips_defines.vh`; no local duplicates.
- One sub-module: `next_pc_sel`, combinational priority mux producing the next PC, `redirect` and the misalignment flag.
- The PC register and IF/ID register stay in `instruction_fetch`.

## Test plan

- Reset, then mem[0]=`32'h02114020`, mem[1]=`32'h02534821`, free-run → after edge 1: `ifid_instr`=`02114020`, `ifid_pc_plus4`=4, `valid`=1; after edge 2: `02534821`, 8.
- `stall`=1 for 3 cycles at `pc`=8 → `pc` stays 8, IF/ID unchanged; release → next edge loads mem[2], `pc`=12.
- `branch_taken`=1, `branch_target`=`32'h40` at `pc`=12 → next edge: `pc`=`32'h40`, `ifid_valid`=0, `ifid_instr`=0; following edge: IF/ID = mem[16], `pc_plus4`=`32'h44`.
- `jump_en`=1 (`jump_target`=`32'h80`) and `branch_taken`=1 (`32'h40`) in the same cycle → `pc`=`32'h80`.
  - Same redirect with `stall`=1 → `pc` holds, redirect ignored.
- Force `pc`=`32'hFFFF_FFFC`, free-run → next `pc`=0.
  - `rst` pulsed asynchronously mid-cycle → `pc`=`RESET_PC` and `valid`=0 before the next edge.
- With `FETCH_ALIGN_CHK_EN`: `jump_target`=`32'h0000_0102` → `pc`=`32'h100`, `misalign_fault`=1 for exactly one cycle.
  - Without the macro: same `pc`, `misalign_fault` stays 0.
